// File: rtl/cipher_pkg.sv
// cipher_pkg: shared state encodings, display characters and key-index width helper
package cipher_pkg;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] KEY  = 3'd1;
  localparam logic [2:0] ENCR = 3'd2;
  localparam logic [2:0] CALC = 3'd3;
  localparam logic [2:0] SEND = 3'd4;
  localparam logic [7:0] SPC_ASCII  = 8'h20;
  localparam logic [7:0] ECHO_ASCII = 8'h2A;
  function automatic int idxw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/enter_edge_sync.sv
// enter_edge_sync: synchronizes the raw enter button and emits a one-cycle pulse on its rising edge
module enter_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enter,
  output logic enter_p
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], enter};
      prev <= sync[SYNC_STAGES-1];
    end
  assign enter_p = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/cipher_session_ctrl.sv
// cipher_session_ctrl: key capture and keyboard -> cipher -> VGA session sequencer.
// Define KEY_ECHO_EN to echo '*' to the display for every stored key byte.
module cipher_session_ctrl
  import cipher_pkg::*;
#(
  parameter int KEY_LEN     = 4,
  parameter int SYNC_STAGES = 2,
  localparam int IDXW       = idxw(KEY_LEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enter,
  input  logic                 kb_valid,
  input  logic [7:0]           kb_char,
  output logic [8*KEY_LEN-1:0] key_out,
  output logic [IDXW-1:0]      key_idx,
  output logic [7:0]           cipher_in,
  input  logic [7:0]           cipher_out,
  output logic                 vga_valid,
  output logic [7:0]           vga_char,
  input  logic                 vga_ready,
  output logic [2:0]           state,
  output logic                 kb_dropped
);
  localparam int CW = $clog2(KEY_LEN + 1);
  logic enter_p, pend, go, busy, last;
  logic [CW-1:0] count;
`ifdef KEY_ECHO_EN
  logic echo, echo_last;
`endif

  enter_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(reset), .enter(enter), .enter_p(enter_p)
  );

  // a pending enter from CALC/SEND acts like a fresh press once the transfer is done
  assign go   = enter_p | pend;
  assign busy = (state == CALC) || (state == SEND);
  assign last = count == CW'(KEY_LEN - 1);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      key_out    <= '0;
      key_idx    <= '0;
      count      <= '0;
      cipher_in  <= SPC_ASCII;
      vga_char   <= SPC_ASCII;
      vga_valid  <= 1'b0;
      kb_dropped <= 1'b0;
      pend       <= 1'b0;
`ifdef KEY_ECHO_EN
      echo       <= 1'b0;
      echo_last  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (enter_p) begin
          state      <= KEY;
          key_out    <= '0;
          key_idx    <= '0;
          count      <= '0;
          kb_dropped <= 1'b0;
          pend       <= 1'b0;
        end
        KEY: if (go) begin
          state <= ENCR;
          pend  <= 1'b0;
        end else if (kb_valid) begin
          key_out[8*count +: 8] <= kb_char;
          count <= count + 1'b1;
`ifdef KEY_ECHO_EN
          vga_char  <= ECHO_ASCII;
          vga_valid <= 1'b1;
          echo      <= 1'b1;
          echo_last <= last;
          state     <= SEND;
`else
          if (last) state <= ENCR;
`endif
        end
        ENCR: if (go) begin
          state   <= IDLE;
          key_out <= '0;
          pend    <= 1'b0;
        end else if (kb_valid) begin
          cipher_in <= kb_char;
          state     <= CALC;
        end
        CALC: begin
          vga_char  <= cipher_out;
          vga_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: if (vga_ready) begin
          vga_valid <= 1'b0;
`ifdef KEY_ECHO_EN
          echo <= 1'b0;
          if (echo) state <= echo_last ? ENCR : KEY;
          else begin
            key_idx <= (key_idx == IDXW'(KEY_LEN - 1)) ? '0 : key_idx + 1'b1;
            state   <= ENCR;
          end
`else
          key_idx <= (key_idx == IDXW'(KEY_LEN - 1)) ? '0 : key_idx + 1'b1;
          state   <= ENCR;
`endif
        end
        default: state <= IDLE;
      endcase
      if (busy && kb_valid) kb_dropped <= 1'b1;
      if (busy && enter_p) pend <= 1'b1;
    end
endmodule
